// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the MULT/DIV sequencer.
// The control unit uses the same operation codes when it drives the op input.
//   OP_MULT / OP_DIV : operation select codes for op
//   state_e          : sequencer FSM state encoding
package muldiv_sequencer_pkg;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the control unit and the MULT/DIV engine.
//   master : control unit side; drives start/op/a_in/b_in and reads the results
//   slave  : engine side; drives busy/done/div_zero/HI_reg_w/LO_reg_w/hi_out/lo_out
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic             HI_reg_w;
    logic             LO_reg_w;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    modport master (
        output start, op, a_in, b_in,
        input  busy, done, div_zero, HI_reg_w, LO_reg_w, hi_out, lo_out
    );

    modport slave (
        input  start, op, a_in, b_in,
        output busy, done, div_zero, HI_reg_w, LO_reg_w, hi_out, lo_out
    );
endinterface

// File: rtl/muldiv_sequencer_datapath.sv
// Arithmetic core of the MULT/DIV engine: operand magnitude registers, the
// shared WIDTH+1 bit adder and the sign-correction logic.
//   clk, rst     : clock and synchronous active-high reset
//   load         : capture op, operand magnitudes and operand signs
//   step         : perform one shift-add (MULT) or restoring-divide (DIV) bit
//   op, a_in, b_in : operation and raw two's-complement operands
//   res_hi/res_lo  : sign-corrected result (product high/low or remainder/quotient)
module muldiv_sequencer_datapath
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic             op_q, op_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;

    logic [WIDTH:0]     add_x, add_y, sum;
    logic               add_cin;
    logic [WIDTH-1:0]   rem_sh;
    logic               rem_ge;
    logic [2*WIDTH-1:0] prod, prod_fix;

    // |v| as an unsigned WIDTH-bit value; |-2^(WIDTH-1)| still fits.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
    endfunction

    // Shared adder: MULT adds |b| into acc_hi when the multiplier bit is set;
    // DIV subtracts |b| from the shifted remainder (add of ~|b| plus carry-in).
    // The remainder is always below |b| <= 2^(WIDTH-1), so after the shift it
    // still fits in WIDTH bits and bit WIDTH of the sum is a clean borrow flag.
    always_comb begin
        rem_sh = {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};
        if (op_q == OP_DIV) begin
            add_x   = {1'b0, rem_sh};
            add_y   = ~{1'b0, divisor_q};
            add_cin = 1'b1;
        end else begin
            add_x   = {1'b0, acc_hi_q};
            add_y   = acc_lo_q[0] ? {1'b0, divisor_q} : '0;
            add_cin = 1'b0;
        end
        sum    = add_x + add_y + (WIDTH+1)'(add_cin);
        rem_ge = ~sum[WIDTH];
    end

    always_comb begin
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        divisor_d = divisor_q;
        op_d      = op_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        if (load) begin
            op_d      = op;
            sign_a_d  = a_in[WIDTH-1];
            sign_b_d  = b_in[WIDTH-1];
            acc_hi_d  = '0;
            acc_lo_d  = magnitude(a_in);
            divisor_d = magnitude(b_in);
        end else if (step) begin
            if (op_q == OP_DIV) begin
                acc_hi_d = rem_ge ? sum[WIDTH-1:0] : rem_sh;
                acc_lo_d = {acc_lo_q[WIDTH-2:0], rem_ge};
            end else begin
                // Carry out of the add shifts into the top of acc_hi.
                acc_hi_d = sum[WIDTH:1];
                acc_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            divisor_q <= '0;
            op_q      <= 1'b0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
        end else begin
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            divisor_q <= divisor_d;
            op_q      <= op_d;
            sign_a_q  <= sign_a_d;
            sign_b_q  <= sign_b_d;
        end
    end

    // Sign correction: quotient/product follow sign(a)^sign(b); the remainder
    // follows the dividend so that division truncates toward zero.
    always_comb begin
        prod     = {acc_hi_q, acc_lo_q};
        prod_fix = (sign_a_q ^ sign_b_q) ? -prod : prod;
        if (op_q == OP_DIV) begin
            res_lo = (sign_a_q ^ sign_b_q) ? -acc_lo_q : acc_lo_q;
            res_hi = sign_a_q ? -acc_hi_q : acc_hi_q;
        end else begin
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multicycle signed MULT/DIV engine: FSM, iteration counter, result registers
// and the done/write-enable pulses seen by the control unit.
//   clk      : system clock
//   reset_in : synchronous active-high reset; aborts any operation in flight
//   bus      : muldiv_sequencer_if slave (start/op/a_in/b_in in;
//              busy/done/div_zero/HI_reg_w/LO_reg_w/hi_out/lo_out out)
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 reset_in,
    muldiv_sequencer_if.slave    bus
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_out_q, hi_out_d;
    logic [WIDTH-1:0] lo_out_q, lo_out_d;

    logic             load, step;
    logic [WIDTH-1:0] res_hi, res_lo;

    muldiv_sequencer_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk    (clk),
        .rst    (reset_in),
        .load   (load),
        .step   (step),
        .op     (bus.op),
        .a_in   (bus.a_in),
        .b_in   (bus.b_in),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dz_d     = dz_q;
        hi_out_d = hi_out_q;
        lo_out_d = lo_out_q;
        load     = 1'b0;
        step     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    load  = 1'b1;
                    cnt_d = '0;
                    // Divide-by-zero skips the iterations but still passes
                    // through FIX, giving its done pulse a two-cycle latency.
                    if (bus.op == OP_DIV && bus.b_in == '0) begin
                        dz_d    = 1'b1;
                        state_d = S_FIX;
                    end else begin
                        dz_d    = 1'b0;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                step  = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                // Results are registered here so they are valid during done.
                if (!dz_q) begin
                    hi_out_d = res_hi;
                    lo_out_d = res_lo;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_in) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            dz_q     <= 1'b0;
            hi_out_q <= '0;
            lo_out_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dz_q     <= dz_d;
            hi_out_q <= hi_out_d;
            lo_out_q <= lo_out_d;
        end
    end

    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = (state_q == S_DONE);
    assign bus.div_zero = (state_q == S_DONE) &&  dz_q;
    assign bus.HI_reg_w = (state_q == S_DONE) && !dz_q;
    assign bus.LO_reg_w = (state_q == S_DONE) && !dz_q;
    assign bus.hi_out   = hi_out_q;
    assign bus.lo_out   = lo_out_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer.
module tb_muldiv_sequencer;

    logic clk;
    logic reset_in;
    int   n_cmp;
    int   n_fail;

    int          lat;
    logic [31:0] r_hi, r_lo;
    logic        r_dz, r_hw, r_lw, r_busy, r_done_next;

    muldiv_sequencer_if #(.WIDTH(32)) bus ();

    muldiv_sequencer #(
        .WIDTH (32),
        .CNT_W (5)
    ) dut (
        .clk      (clk),
        .reset_in (reset_in),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation in the current cycle and wait (bounded) for done.
    // lat = number of edges after the sampling edge until done is seen; -1 on timeout.
    task automatic run_op(input logic op_i, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op_i;
        bus.a_in  = a;
        bus.b_in  = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                lat = i;
                break;
            end
        end
        r_hi   = bus.hi_out;
        r_lo   = bus.lo_out;
        r_dz   = bus.div_zero;
        r_hw   = bus.HI_reg_w;
        r_lw   = bus.LO_reg_w;
        r_busy = bus.busy;
        @(posedge clk); #1;
        r_done_next = bus.done;
    endtask

    task automatic test_reset();
        reset_in  = 1'b1;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
        n_cmp++; if ({bus.div_zero, bus.HI_reg_w, bus.LO_reg_w} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses: got %b want 000", {bus.div_zero, bus.HI_reg_w, bus.LO_reg_w}); end
        n_cmp++; if ({bus.hi_out, bus.lo_out} !== 64'h0) begin n_fail++; $display("FAIL reset_hilo: got %h want 0", {bus.hi_out, bus.lo_out}); end
        reset_in = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mult();
        run_op(1'b0, 32'd7, 32'hFFFF_FFFD);
        n_cmp++; if (lat !== 33) begin n_fail++; $display("FAIL mult1_latency: got %0d want 33", lat); end
        n_cmp++; if (r_hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult1_hi: got %h want ffffffff", r_hi); end
        n_cmp++; if (r_lo !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mult1_lo: got %h want ffffffeb", r_lo); end
        n_cmp++; if ({r_hw, r_lw, r_dz} !== 3'b110) begin n_fail++; $display("FAIL mult1_pulses: got %b want 110", {r_hw, r_lw, r_dz}); end
        n_cmp++; if (r_busy !== 1'b1) begin n_fail++; $display("FAIL mult1_busy_in_done: got %b want 1", r_busy); end
        n_cmp++; if (r_done_next !== 1'b0) begin n_fail++; $display("FAIL mult1_done_width: got %b want 0", r_done_next); end

        run_op(1'b0, 32'h8000_0000, 32'h8000_0000);
        n_cmp++; if (r_hi !== 32'h4000_0000) begin n_fail++; $display("FAIL mult_min_hi: got %h want 40000000", r_hi); end
        n_cmp++; if (r_lo !== 32'h0000_0000) begin n_fail++; $display("FAIL mult_min_lo: got %h want 00000000", r_lo); end
    endtask

    task automatic test_div();
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2);
        n_cmp++; if (lat !== 33) begin n_fail++; $display("FAIL div1_latency: got %0d want 33", lat); end
        n_cmp++; if (r_lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div1_quo: got %h want fffffffd", r_lo); end
        n_cmp++; if (r_hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div1_rem: got %h want ffffffff", r_hi); end

        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        n_cmp++; if (r_lo !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf_quo: got %h want 80000000", r_lo); end
        n_cmp++; if (r_hi !== 32'h0000_0000) begin n_fail++; $display("FAIL div_ovf_rem: got %h want 00000000", r_hi); end
        n_cmp++; if (r_dz !== 1'b0) begin n_fail++; $display("FAIL div_ovf_dz: got %b want 0", r_dz); end

        run_op(1'b1, 32'd7, 32'hFFFF_FFFE);
        n_cmp++; if (r_lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div2_quo: got %h want fffffffd", r_lo); end
        n_cmp++; if (r_hi !== 32'h0000_0001) begin n_fail++; $display("FAIL div2_rem: got %h want 00000001", r_hi); end
    endtask

    // Follows the 7 / -2 division, so hi=1, lo=-3 must survive.
    task automatic test_div_zero();
        run_op(1'b1, 32'd5, 32'd0);
        n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL dz_latency: got %0d want 1", lat); end
        n_cmp++; if ({r_dz, r_hw, r_lw} !== 3'b100) begin n_fail++; $display("FAIL dz_pulses: got %b want 100", {r_dz, r_hw, r_lw}); end
        n_cmp++; if (r_hi !== 32'h0000_0001) begin n_fail++; $display("FAIL dz_hi_kept: got %h want 00000001", r_hi); end
        n_cmp++; if (r_lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL dz_lo_kept: got %h want fffffffd", r_lo); end
        n_cmp++; if (r_done_next !== 1'b0) begin n_fail++; $display("FAIL dz_done_width: got %b want 0", r_done_next); end
    endtask

    task automatic test_start_while_busy();
        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.a_in  = 32'd100;
        bus.b_in  = 32'd200;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                lat = i;
                break;
            end
            bus.start = (i == 5 || i == 20);
            bus.op    = 1'b1;
            bus.a_in  = 32'd9;
            bus.b_in  = 32'd3;
        end
        n_cmp++; if (lat !== 33) begin n_fail++; $display("FAIL busy_latency: got %0d want 33", lat); end
        n_cmp++; if (bus.lo_out !== 32'd20000) begin n_fail++; $display("FAIL busy_lo: got %h want %h", bus.lo_out, 32'd20000); end
        n_cmp++; if (bus.hi_out !== 32'd0) begin n_fail++; $display("FAIL busy_hi: got %h want 00000000", bus.hi_out); end
        // Start presented during the DONE cycle must not be accepted.
        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.a_in  = 32'd2;
        bus.b_in  = 32'd2;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL start_in_done_busy: got %b want 0", bus.busy); end
        @(posedge clk); #1;
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL start_in_done_idle: got %b want 0", bus.busy); end
    endtask

    task automatic test_back_to_back();
        run_op(1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFA);
        n_cmp++; if ({r_hi, r_lo} !== 64'd30) begin n_fail++; $display("FAIL b2b_first: got %h want %h", {r_hi, r_lo}, 64'd30); end
        // Issued in the first IDLE cycle after the previous done.
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        n_cmp++; if (lat !== 33) begin n_fail++; $display("FAIL b2b_latency: got %0d want 33", lat); end
        n_cmp++; if ({r_hi, r_lo} !== 64'd1) begin n_fail++; $display("FAIL b2b_second: got %h want %h", {r_hi, r_lo}, 64'd1); end
    endtask

    task automatic test_reset_mid();
        int seen;
        seen      = 0;
        bus.start = 1'b1;
        bus.op    = 1'b1;
        bus.a_in  = 32'd100;
        bus.b_in  = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 1; i < 10; i++) begin
            @(posedge clk); #1;
        end
        reset_in = 1'b1;
        @(posedge clk); #1;
        reset_in = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
        n_cmp++; if ({bus.done, bus.div_zero, bus.HI_reg_w, bus.LO_reg_w} !== 4'b0000) begin n_fail++; $display("FAIL rstmid_pulses: got %b want 0000", {bus.done, bus.div_zero, bus.HI_reg_w, bus.LO_reg_w}); end
        n_cmp++; if ({bus.hi_out, bus.lo_out} !== 64'h0) begin n_fail++; $display("FAIL rstmid_hilo: got %h want 0", {bus.hi_out, bus.lo_out}); end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d done cycles want 0", seen); end
        run_op(1'b0, 32'd3, 32'd4);
        n_cmp++; if (lat !== 33) begin n_fail++; $display("FAIL rstmid_mult_latency: got %0d want 33", lat); end
        n_cmp++; if (r_lo !== 32'd12) begin n_fail++; $display("FAIL rstmid_mult_lo: got %h want 0000000c", r_lo); end
        n_cmp++; if (r_hi !== 32'd0) begin n_fail++; $display("FAIL rstmid_mult_hi: got %h want 00000000", r_hi); end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
